// File: rtl/dsp_shift_round_sat.sv
// Output scaling stage: runtime right shift, optional half-up rounding and
// optional saturation, as a two-register valid/ready pipeline.
module dsp_shift_round_sat #(
  parameter int SIGNED = 0,
  parameter int IN_W   = 38,
  parameter int OUT_W  = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  z_in,
  input  logic [5:0]       shift_amt,
  input  logic             round_en,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  localparam int TW = IN_W + 1;

  localparam logic [OUT_W-1:0] U_MAX = '1;
  localparam logic [OUT_W-1:0] S_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] S_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic                 s1_valid;
  logic                 s2_valid;
  logic                 s1_load;
  logic                 s2_load;
  logic [TW-1:0]        s1_t;
  logic                 s1_round;
  logic                 s1_sat;

  logic                 round_act;
  logic [5:0]           sh;
  logic [TW-1:0]        z_ext;
  logic signed [TW-1:0] z_s;
  logic [TW-1:0]        t_shift;
  logic [TW-1:0]        t1;

  logic [TW-1:0]        r2;
  logic                 ovf;
  logic                 neg;
  logic [OUT_W-1:0]     d2;
  logic                 sat2;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  // Rounding shifts one bit short, adds one, and drops the last bit in stage 2.
  assign round_act = round_en && (shift_amt != 6'd0);
  assign sh        = round_act ? (shift_amt - 6'd1) : shift_amt;
  assign z_s       = signed'(z_ext);

  if (SIGNED != 0) begin : g_signed
    assign z_ext   = {z_in[IN_W-1], z_in};
    assign t_shift = z_s >>> sh;
    assign r2      = s1_round ? {s1_t[TW-1], s1_t[TW-1:1]} : s1_t;
    assign neg     = r2[TW-1];
    assign ovf     = !((&r2[TW-1:OUT_W-1]) || !(|r2[TW-1:OUT_W-1]));
  end else begin : g_unsigned
    assign z_ext   = {1'b0, z_in};
    assign t_shift = z_ext >> sh;
    assign r2      = s1_round ? {1'b0, s1_t[TW-1:1]} : s1_t;
    assign neg     = 1'b0;
    assign ovf     = |r2[TW-1:OUT_W];
  end

  assign t1 = t_shift + {{(TW-1){1'b0}}, round_act};

  always_comb begin
    d2   = r2[OUT_W-1:0];
    sat2 = 1'b0;
    if (s1_sat && ovf) begin
      sat2 = 1'b1;
      if (SIGNED != 0) begin
        d2 = neg ? S_MIN : S_MAX;
      end else begin
        d2 = U_MAX;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_t     <= '0;
      s1_round <= 1'b0;
      s1_sat   <= 1'b0;
      s2_valid <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_t     <= t1;
          s1_round <= round_act;
          s1_sat   <= sat_en;
        end
      end
      // Output registers only change on a real transfer, so a stalled beat holds.
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= d2;
          out_sat  <= sat2;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsp_shift_round_sat.sv
// Bench for dsp_shift_round_sat: unsigned and signed instances driven in
// parallel, checked against an arithmetic reference model and directed cases.
module tb_dsp_shift_round_sat;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [37:0] z_in = '0;
  logic [5:0]  shift_amt = '0;
  logic        round_en = 1'b0;
  logic        sat_en = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [19:0] out_data0, out_data1;
  logic        out_sat0, out_sat1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [19:0] d0;
    logic        s0;
    logic [19:0] d1;
    logic        s1;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  dsp_shift_round_sat #(.SIGNED(0), .IN_W(38), .OUT_W(20)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .z_in(z_in), .shift_amt(shift_amt), .round_en(round_en), .sat_en(sat_en),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_sat(out_sat0)
  );

  dsp_shift_round_sat #(.SIGNED(1), .IN_W(38), .OUT_W(20)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .z_in(z_in), .shift_amt(shift_amt), .round_en(round_en), .sat_en(sat_en),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_sat(out_sat1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: floor((v + half) / 2^s) for rounding, floor(v / 2^s) otherwise.
  function automatic void model(input logic [37:0] z, input int s, input bit r, input bit sat,
                                input bit sgn, output logic [19:0] d, output logic os);
    longint v, q, dv, num, hi, lo;
    v = sgn ? longint'($signed(z)) : longint'({26'd0, z});
    if (s >= 40) begin
      q = (r && s > 0) ? 64'sd0 : ((v < 0) ? -64'sd1 : 64'sd0);
    end else begin
      dv  = longint'(1) << s;
      num = (r && s > 0) ? v + dv / 2 : v;
      q   = num / dv;
      if (q * dv > num) q = q - 1;
    end
    hi = sgn ? (longint'(1) << 19) - 1 : (longint'(1) << 20) - 1;
    lo = sgn ? -(longint'(1) << 19) : 64'sd0;
    if (sat && q > hi) begin
      d = hi[19:0]; os = 1'b1;
    end else if (sat && q < lo) begin
      d = lo[19:0]; os = 1'b1;
    end else begin
      d = q[19:0]; os = 1'b0;
    end
  endfunction

  logic        stall_prev = 1'b0;
  logic [19:0] held_d0, held_d1;
  logic        held_s0, held_s1;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      chk("in_ready u0", {63'd0, in_ready0}, {63'd0, (sb.size() < 2) || out_ready});
      chk("in_ready u1", {63'd0, in_ready1}, {63'd0, (sb.size() < 2) || out_ready});
      if (stall_prev) begin
        chk("hold valid", {63'd0, out_valid0}, 64'd1);
        chk("hold data u0", {44'd0, out_data0}, {44'd0, held_d0});
        chk("hold sat u0", {63'd0, out_sat0}, {63'd0, held_s0});
        chk("hold data u1", {44'd0, out_data1}, {44'd0, held_d1});
        chk("hold sat u1", {63'd0, out_sat1}, {63'd0, held_s1});
      end
      if (out_valid0 && out_ready) begin
        if (sb.size() == 0) begin
          chk("stale beat", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("data u0", {44'd0, out_data0}, {44'd0, e.d0});
          chk("sat u0", {63'd0, out_sat0}, {63'd0, e.s0});
          chk("valid u1", {63'd0, out_valid1}, 64'd1);
          chk("data u1", {44'd0, out_data1}, {44'd0, e.d1});
          chk("sat u1", {63'd0, out_sat1}, {63'd0, e.s1});
        end
      end
      if (in_valid && in_ready0) begin
        exp_t e;
        model(z_in, int'(shift_amt), round_en, sat_en, 1'b0, e.d0, e.s0);
        model(z_in, int'(shift_amt), round_en, sat_en, 1'b1, e.d1, e.s1);
        sb.push_back(e);
      end
      stall_prev = out_valid0 && !out_ready;
      held_d0 = out_data0; held_s0 = out_sat0;
      held_d1 = out_data1; held_s1 = out_sat1;
    end
  end

  // One beat into an empty pipeline with out_ready high; out_valid must rise
  // at the second edge counting the accepting one.
  task automatic run_vec(input string tag, input logic [37:0] z, input logic [5:0] s,
                         input logic r, input logic sat, input bit use_u1,
                         input logic [19:0] ed, input logic es);
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1;
    z_in = z; shift_amt = s; round_en = r; sat_en = sat;
    @(negedge clk);
    chk({tag, " accept"}, {63'd0, use_u1 ? in_ready1 : in_ready0}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, " early"}, {63'd0, use_u1 ? out_valid1 : out_valid0}, 64'd0);
    @(negedge clk);
    chk({tag, " valid"}, {63'd0, use_u1 ? out_valid1 : out_valid0}, 64'd1);
    chk({tag, " data"}, {44'd0, use_u1 ? out_data1 : out_data0}, {44'd0, ed});
    chk({tag, " sat"}, {63'd0, use_u1 ? out_sat1 : out_sat0}, {63'd0, es});
    $display("vec %s: z=%0h s=%0d r=%0b sat=%0b -> %0h/%0b", tag, z, s, r, sat,
             use_u1 ? out_data1 : out_data0, use_u1 ? out_sat1 : out_sat0);
  endtask

  initial begin
    bit acc;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst valid u0", {63'd0, out_valid0}, 64'd0);
    chk("rst data u0", {44'd0, out_data0}, 64'd0);
    chk("rst sat u0", {63'd0, out_sat0}, 64'd0);
    chk("rst valid u1", {63'd0, out_valid1}, 64'd0);
    chk("rst data u1", {44'd0, out_data1}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst in_ready", {63'd0, in_ready0}, 64'd1);

    run_vec("u shift1",   38'd4606, 6'd1,  1'b0, 1'b1, 1'b0, 20'd2303, 1'b0);
    run_vec("u rnd12",    38'd4606, 6'd12, 1'b1, 1'b1, 1'b0, 20'd1,    1'b0);
    run_vec("u tie",      38'd6,    6'd2,  1'b1, 1'b1, 1'b0, 20'd2,    1'b0);
    run_vec("u trunc",    38'd6,    6'd2,  1'b0, 1'b1, 1'b0, 20'd1,    1'b0);
    run_vec("u sat",      38'h3F_FFFF_FFFF, 6'd0,  1'b0, 1'b1, 1'b0, 20'hFFFFF, 1'b1);
    run_vec("u wrap",     38'h3F_FFFF_FFFF, 6'd0,  1'b0, 1'b0, 1'b0, 20'hFFFFF, 1'b0);
    run_vec("u shift63",  38'h3F_FFFF_FFFF, 6'd63, 1'b0, 1'b1, 1'b0, 20'd0,     1'b0);
    run_vec("s rnd neg",  -38'sd6,          6'd2,  1'b1, 1'b1, 1'b1, 20'hFFFFF, 1'b0);
    run_vec("s sat neg",  -(38'sd1 <<< 30), 6'd0,  1'b0, 1'b1, 1'b1, 20'h80000, 1'b1);
    run_vec("s big rnd",  -38'sd5,          6'd50, 1'b1, 1'b1, 1'b1, 20'd0,     1'b0);

    // Backpressure: two beats buffer, the third waits until the head leaves.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; z_in = 38'd100;
    shift_amt = 6'd0; round_en = 1'b0; sat_en = 1'b1;
    @(negedge clk); chk("bp A accept", {63'd0, in_ready0}, 64'd1);
    @(posedge clk); #1; z_in = 38'd200;
    @(negedge clk); chk("bp B accept", {63'd0, in_ready0}, 64'd1);
    @(posedge clk); #1; z_in = 38'd300;
    @(negedge clk);
    chk("bp C blocked", {63'd0, in_ready0}, 64'd0);
    chk("bp head", {44'd0, out_data0}, 64'd100);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp still blocked", {63'd0, in_ready0}, 64'd0);
    chk("bp head held", {44'd0, out_data0}, 64'd100);
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    chk("bp C accept", {63'd0, in_ready0}, 64'd1);
    chk("bp out A", {44'd0, out_data0}, 64'd100);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); chk("bp out B", {44'd0, out_data0}, 64'd200);
    @(negedge clk); chk("bp out C", {44'd0, out_data0}, 64'd300);
    @(negedge clk); chk("bp empty", {63'd0, out_valid0}, 64'd0);
    $display("backpressure: A/B/C sequence done");

    // Reset with two beats in flight.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; z_in = 38'd1234;
    @(posedge clk); #1; z_in = 38'd5678;
    @(posedge clk); #1; in_valid = 1'b0;
    chk("pre-rst full", {63'd0, out_valid0}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst valid", {63'd0, out_valid0}, 64'd0);
    chk("mid-rst data", {44'd0, out_data0}, 64'd0);
    chk("mid-rst data u1", {44'd0, out_data1}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("reset: pipeline flushed");
    run_vec("after rst", 38'd77, 6'd0, 1'b0, 1'b1, 1'b0, 20'd77, 1'b0);

    // Random traffic with random backpressure; the monitor scores every beat.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready0;
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 9) < 7);
        case ($urandom_range(0, 3))
          0: z_in = {$urandom, $urandom};
          1: z_in = 38'($urandom_range(0, 32'h00FF_FFFF));
          2: z_in = 38'($urandom_range(0, 255));
          default: z_in = -38'($urandom_range(0, 32'h0FFF_FFFF));
        endcase
        shift_amt = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 24));
        round_en  = 1'($urandom);
        sat_en    = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
    chk("drain valid", {63'd0, out_valid0}, 64'd0);
    $display("random: traffic drained");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
